// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the serial sequence detector:
//   - state_t   : detector FSM states (IDLE, FILL, ARMED)
//   - PAT_W_MIN / PAT_W_MAX : legal range of the pattern length parameter
//   - fill_width(): width needed to hold a fill count of 0..pat_w
// -----------------------------------------------------------------------------
package seq_detect_pkg;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no pattern loaded; input stream ignored
      FILL  = 2'd1,   // fewer than PAT_W bits collected since (re)start
      ARMED = 2'd2    // history holds PAT_W valid bits; every new bit is compared
   } state_t;

   // Fill counts 0..pat_w inclusive, so one extra code point is needed.
   function automatic int fill_width(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage : seq_detect_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at its all-ones value.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears q)
//   clr : synchronous clear (same effect as rst, lower priority name only)
//   inc : add one on this edge unless already saturated
//   q   : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial bit-pattern detector with per-bit don't-care mask and selectable
// overlapping / non-overlapping matching.
// Optional feature: define SEQ_DETECT_MATCH_CNT_EN to add the saturating
// match counter and its match_cnt output port.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, highest priority
//   in        : serial data bit
//   in_valid  : in is consumed only on edges where this is high
//   pattern   : target sequence, pattern[PAT_W-1] is the first-received bit
//   pat_mask  : 1 = compare this bit, 0 = don't-care
//   pat_load  : latch pattern/pat_mask/overlap and restart detection
//   overlap   : 1 = overlapping matches allowed
//   out       : registered one-cycle match pulse
//   match_cnt : saturating match count (SEQ_DETECT_MATCH_CNT_EN only)
// -----------------------------------------------------------------------------
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic [PAT_W-1:0] pattern,
   input  logic [PAT_W-1:0] pat_mask,
   input  logic             pat_load,
   input  logic             overlap,
   output logic             out
`ifdef SEQ_DETECT_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   localparam int FILL_W = fill_width(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W out of legal range");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W must be at least 1");
   end

   state_t             state, state_next;
   logic [PAT_W-1:0]   history, history_next;
   logic [FILL_W-1:0]  fill, fill_next, fill_inc;
   logic [PAT_W-1:0]   pat_reg, pat_next;
   logic [PAT_W-1:0]   mask_reg, mask_next;
   logic               overlap_reg, overlap_next;
   logic               out_next;
   logic [PAT_W-1:0]   shifted;
   logic               hit;

   // Candidate values for an accepted bit: newest bit enters at bit 0,
   // fill saturates at PAT_W so an armed detector stays armed.
   assign shifted  = {history[PAT_W-2:0], in};
   assign fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
   assign hit      = (fill_inc == FILL_FULL) &&
                     (((shifted ^ pat_reg) & mask_reg) == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         history     <= '0;
         fill        <= '0;
         pat_reg     <= '0;
         mask_reg    <= '0;
         overlap_reg <= 1'b0;
         out         <= 1'b0;
      end else begin
         state       <= state_next;
         history     <= history_next;
         fill        <= fill_next;
         pat_reg     <= pat_next;
         mask_reg    <= mask_next;
         overlap_reg <= overlap_next;
         out         <= out_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // which keeps it purely combinational (no inferred latches).
      state_next   = state;
      history_next = history;
      fill_next    = fill;
      pat_next     = pat_reg;
      mask_next    = mask_reg;
      overlap_next = overlap_reg;
      out_next     = 1'b0;

      if (pat_load) begin
         // A load restarts detection; a bit presented on the same edge is dropped.
         pat_next     = pattern;
         mask_next    = pat_mask;
         overlap_next = overlap;
         history_next = '0;
         fill_next    = '0;
         state_next   = FILL;
      end else if (state != IDLE && in_valid) begin
         history_next = shifted;
         out_next     = hit;
         if (hit && !overlap_reg) begin
            // Non-overlapping: the next match needs PAT_W fresh bits.
            fill_next  = '0;
            state_next = FILL;
         end else begin
            fill_next  = fill_inc;
            state_next = (fill_inc == FILL_FULL) ? ARMED : FILL;
         end
      end
   end

`ifdef SEQ_DETECT_MATCH_CNT_EN
   // Counts on the same edge that raises out, so match_cnt and out agree.
   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .clr (pat_load),
      .inc (out_next),
      .q   (match_cnt)
   );
`endif

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
// Directed self-checking bench for seq_detect_param (PAT_W=3, CNT_W=2).
// Counter checks are compiled in only when SEQ_DETECT_MATCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;
   import seq_detect_pkg::*;

   localparam int PAT_W = 3;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in;
   logic             in_valid;
   logic [PAT_W-1:0] pattern;
   logic [PAT_W-1:0] pat_mask;
   logic             pat_load;
   logic             overlap;
   logic             out;
`ifdef SEQ_DETECT_MATCH_CNT_EN
   logic [CNT_W-1:0] match_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   seq_detect_param #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .in_valid (in_valid),
      .pattern  (pattern),
      .pat_mask (pat_mask),
      .pat_load (pat_load),
      .overlap  (overlap),
      .out      (out)
`ifdef SEQ_DETECT_MATCH_CNT_EN
      ,
      .match_cnt(match_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then settle just past it before anything is sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m, input logic ov);
      pattern  = p;
      pat_mask = m;
      overlap  = ov;
      pat_load = 1'b1;
      tick();
      pat_load = 1'b0;
   endtask

   // Present one valid bit, then check the pulse registered on that edge.
   task automatic send(input logic b, input logic exp_out, input string tag);
      in       = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check(tag, 32'(out), 32'(exp_out));
   endtask

   task automatic check_state(input string tag, input state_t exp);
      check(tag, 32'(dut.state), 32'(exp));
   endtask

   initial begin
      rst      = 1'b1;
      in       = 1'b0;
      in_valid = 1'b0;
      pattern  = '0;
      pat_mask = '0;
      pat_load = 1'b0;
      overlap  = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_out", 32'(out), 32'd0);
      check_state("rst_state", IDLE);
      check("rst_fill", 32'(dut.fill), 32'd0);
      check("rst_pat", 32'(dut.pat_reg), 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      check("rst_cnt", 32'(match_cnt), 32'd0);
`endif
      rst = 1'b0;

      // IDLE ignores the stream, even one that would match an all-zero mask
      send(1'b0, 1'b0, "idle_b1");
      send(1'b0, 1'b0, "idle_b2");
      send(1'b0, 1'b0, "idle_b3");
      check_state("idle_hold", IDLE);

      // 010 / 111 overlapping over 0,1,0,1,0 -> pulses after bits 3 and 5
      load(3'b010, 3'b111, 1'b1);
      check_state("ld_state", FILL);
      check("ld_fill", 32'(dut.fill), 32'd0);
      send(1'b0, 1'b0, "ov_b1");
      send(1'b1, 1'b0, "ov_b2");
      send(1'b0, 1'b1, "ov_b3");
      check_state("ov_armed", ARMED);
      send(1'b1, 1'b0, "ov_b4");
      send(1'b0, 1'b1, "ov_b5");
      tick();
      check("ov_pulse_end", 32'(out), 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      check("ov_cnt", 32'(match_cnt), 32'd2);
`endif

      // Same stream, non-overlapping -> pulse after bit 3 only
      load(3'b010, 3'b111, 1'b0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      check("ld_cnt_clr", 32'(match_cnt), 32'd0);
`endif
      send(1'b0, 1'b0, "nov_b1");
      send(1'b1, 1'b0, "nov_b2");
      send(1'b0, 1'b1, "nov_b3");
      check("nov_fill_clr", 32'(dut.fill), 32'd0);
      check_state("nov_refill", FILL);
      send(1'b1, 1'b0, "nov_b4");
      send(1'b0, 1'b0, "nov_b5");
`ifdef SEQ_DETECT_MATCH_CNT_EN
      check("nov_cnt", 32'(match_cnt), 32'd1);
`endif

      // Middle bit masked off: 000 matches 010/101
      load(3'b010, 3'b101, 1'b1);
      send(1'b0, 1'b0, "msk_b1");
      send(1'b0, 1'b0, "msk_b2");
      send(1'b0, 1'b1, "msk_b3");

      // in_valid gap of 4 cycles between bits 2 and 3
      load(3'b010, 3'b111, 1'b1);
      send(1'b0, 1'b0, "gap_b1");
      send(1'b1, 1'b0, "gap_b2");
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("gap_idle%0d", i), 32'(out), 32'd0);
      end
      send(1'b0, 1'b1, "gap_b3");
      tick();
      check("gap_single", 32'(out), 32'd0);

      // Reset mid-sequence discards the partial match and needs a new load
      load(3'b010, 3'b111, 1'b1);
      send(1'b0, 1'b0, "mrst_b1");
      send(1'b1, 1'b0, "mrst_b2");
      rst = 1'b1;
      in = 1'b0;
      in_valid = 1'b1;
      pat_load = 1'b1;   // reset outranks both
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      pat_load = 1'b0;
      check_state("mrst_state", IDLE);
      check("mrst_out", 32'(out), 32'd0);
      check("mrst_mask", 32'(dut.mask_reg), 32'd0);
      send(1'b0, 1'b0, "mrst_b3");
      send(1'b1, 1'b0, "mrst_b4");
      send(1'b0, 1'b0, "mrst_b5");
      check_state("mrst_idle", IDLE);

      // pat_load wins over a simultaneous valid bit
      load(3'b010, 3'b111, 1'b1);
      send(1'b0, 1'b0, "plv_pre1");
      send(1'b1, 1'b0, "plv_pre2");
      in       = 1'b0;
      in_valid = 1'b1;
      pat_load = 1'b1;
      tick();
      pat_load = 1'b0;
      in_valid = 1'b0;
      check("plv_out", 32'(out), 32'd0);
      check("plv_fill", 32'(dut.fill), 32'd0);
      check("plv_hist", 32'(dut.history), 32'd0);
      send(1'b0, 1'b0, "plv_b1");
      send(1'b1, 1'b0, "plv_b2");
      send(1'b0, 1'b1, "plv_b3");

      // All-zero mask matches every bit once full; 5 matches saturate a 2-bit count
      load(3'b101, 3'b000, 1'b1);
      send(1'b1, 1'b0, "all_b1");
      send(1'b0, 1'b0, "all_b2");
      for (int i = 3; i <= 7; i++) begin
         send(1'(i), 1'b1, $sformatf("all_b%0d", i));
      end
`ifdef SEQ_DETECT_MATCH_CNT_EN
      check("sat_cnt", 32'(match_cnt), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seq_detect_param
